// File: rtl/product_bcd_pkg.sv
// Shared types and default sizing for the product-to-BCD converter.
package product_bcd_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int DIGITS_DEF = 5;
    localparam int BCD_W_DEF  = 4 * DIGITS_DEF;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

endpackage

// File: rtl/product_bcd_digit_adjust.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adjust (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Values 5..9 map to 8..12, so the 4-bit add never wraps.
    always_comb begin
        digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;
    end

endmodule

// File: rtl/product_bcd.sv
// Captures a multiplier product on the rising edge of READY and converts it
// serially to packed BCD, one bit per clock, with a one-deep pending buffer.
//
// state   | meaning
// IDLE    | waiting for a READY rising edge
// CONVERT | shifting the product through the add-3 chain, count bits left
module product_bcd
    import product_bcd_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clock,
    input  logic                  n_reset,
    input  logic                  READY,
    input  logic [WIDTH-1:0]      AQ,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  VALID,
    output logic                  BUSY,
    output logic                  OVERRUN
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam int CW    = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

    state_t            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  pend_q, pend_d;
    logic              pending_q, pending_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              ready_q;

    logic              cap;
    logic              done;
    logic [BCD_W-1:0]  adj_w;
    logic [SR_W-1:0]   sr_adj;
    logic [SR_W-1:0]   sr_shift;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adjust u_adj (
                .digit_i (sr_q[WIDTH + 4*g +: 4]),
                .digit_o (adj_w[4*g +: 4])
            );
        end
    endgenerate

    // One conversion step: corrected scratch digits, then shift everything left.
    always_comb begin
        sr_adj   = {adj_w, sr_q[WIDTH-1:0]};
        sr_shift = sr_adj << 1;
    end

    // Next-state logic: edge capture, conversion sequencing and pending buffer.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        count_d   = count_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        bcd_d     = bcd_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        cap       = READY & ~ready_q;
        done      = (count_q == CW'(1));

        case (state_q)
            IDLE: begin
                if (cap) begin
                    sr_d    = {{BCD_W{1'b0}}, AQ};
                    count_d = CNT_LOAD;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                sr_d    = sr_shift;
                count_d = count_q - CW'(1);
                if (done) begin
                    bcd_d   = sr_shift[SR_W-1:WIDTH];
                    valid_d = 1'b1;
                    if (pending_q) begin
                        // Pending value starts now; a simultaneous capture refills the buffer.
                        sr_d      = {{BCD_W{1'b0}}, pend_q};
                        count_d   = CNT_LOAD;
                        pending_d = cap;
                        if (cap) pend_d = AQ;
                    end else if (cap) begin
                        sr_d    = {{BCD_W{1'b0}}, AQ};
                        count_d = CNT_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cap) begin
                    // Newest product wins; a full buffer means one product is lost.
                    if (pending_q) overrun_d = 1'b1;
                    pend_d    = AQ;
                    pending_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; ready_q resets high so a READY held through reset is ignored.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            count_q   <= '0;
            pend_q    <= '0;
            pending_q <= 1'b0;
            bcd_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            count_q   <= count_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            ready_q   <= READY;
        end
    end

    assign BCD     = bcd_q;
    assign VALID   = valid_q;
    assign BUSY    = (state_q == CONVERT);
    assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_product_bcd.sv
// Bench for product_bcd: transaction-level reference model plus directed and random scenarios.
module tb_product_bcd;

    logic        clock = 1'b0;
    logic        n_reset;
    logic        READY;
    logic [15:0] AQ;
    logic [19:0] BCD;
    logic        VALID;
    logic        BUSY;
    logic        OVERRUN;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: a conversion started at edge t delivers at edge t+16.
    bit          m_active;
    int          m_end;
    int unsigned m_cur;
    bit          m_pend_v;
    int unsigned m_pend;
    bit          m_ovr;
    logic [19:0] m_bcd;
    bit          m_valid;
    bit          m_prev_ready;

    product_bcd dut (
        .clock   (clock),
        .n_reset (n_reset),
        .READY   (READY),
        .AQ      (AQ),
        .BCD     (BCD),
        .VALID   (VALID),
        .BUSY    (BUSY),
        .OVERRUN (OVERRUN)
    );

    always #5 clock = ~clock;

    function automatic logic [19:0] to_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_active     = 0;
        m_end        = 0;
        m_cur        = 0;
        m_pend_v     = 0;
        m_pend       = 0;
        m_ovr        = 0;
        m_bcd        = '0;
        m_valid      = 0;
        m_prev_ready = 1;
    endtask

    // Drive one cycle of inputs, advance one rising edge, update the model, settle.
    task automatic step(input logic r, input logic [15:0] a);
        bit cap;
        READY = r;
        AQ    = a;
        @(posedge clock);
        cyc++;
        cap          = r && !m_prev_ready;
        m_prev_ready = r;
        m_valid      = 0;
        if (m_active && cyc == m_end) begin
            m_valid = 1;
            m_bcd   = to_bcd(m_cur);
            if (m_pend_v) begin
                m_cur    = m_pend;
                m_end    = cyc + 16;
                m_pend_v = cap;
                if (cap) m_pend = a;
            end else if (cap) begin
                m_cur = a;
                m_end = cyc + 16;
            end else begin
                m_active = 0;
            end
        end else if (m_active && cap) begin
            if (m_pend_v) m_ovr = 1;
            m_pend   = a;
            m_pend_v = 1;
        end else if (!m_active && cap) begin
            m_active = 1;
            m_cur    = a;
            m_end    = cyc + 16;
        end
        #1;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        READY   = 1'b1;
        AQ      = 16'h1234;
        model_reset();
        #1;
        checks++;
        if ({VALID, BUSY, OVERRUN, BCD} !== 23'h0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", {VALID, BUSY, OVERRUN, BCD});
        end
        @(posedge clock);
        @(posedge clock);
        #1;
        n_reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 16'h1234);
            checks++;
            if ({VALID, BUSY, OVERRUN, BCD} !== 23'h0) begin
                failures++;
                $display("FAIL ready_held_reset cyc=%0d got=%h exp=0", cyc, {VALID, BUSY, OVERRUN, BCD});
            end
        end
    endtask

    task automatic test_single();
        int lat;
        step(1'b0, 16'd0);
        step(1'b1, 16'd12345);
        checks++;
        if (BUSY !== 1'b1) begin
            failures++;
            $display("FAIL single_busy_rise got=%b exp=1", BUSY);
        end
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            step(1'b1, 16'd12345);
            checks++;
            if ({VALID, BUSY, OVERRUN, BCD} !== {m_valid, m_active, m_ovr, m_bcd}) begin
                failures++;
                $display("FAIL single_cycle cyc=%0d got=%h exp=%h", cyc,
                         {VALID, BUSY, OVERRUN, BCD}, {m_valid, m_active, m_ovr, m_bcd});
            end
            if (VALID === 1'b1) lat = i;
        end
        checks++;
        if (lat != 16 || BCD !== 20'h12345) begin
            failures++;
            $display("FAIL single_result latency=%0d bcd=%h exp latency=16 bcd=12345", lat, BCD);
        end
        step(1'b1, 16'd12345);
        checks++;
        if (BUSY !== 1'b0 || VALID !== 1'b0) begin
            failures++;
            $display("FAIL single_after busy=%b valid=%b exp 0 0", BUSY, VALID);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        step(1'b0, 16'd0);
        step(1'b1, 16'd4321);
        for (int i = 0; i < 8; i++) step(1'b1, 16'd4321);
        n_reset = 1'b0;
        #1;
        checks++;
        if ({VALID, BUSY, OVERRUN, BCD} !== 23'h0) begin
            failures++;
            $display("FAIL reset_mid_clear got=%h exp=0", {VALID, BUSY, OVERRUN, BCD});
        end
        @(posedge clock);
        #1;
        n_reset = 1'b1;
        model_reset();
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 16'd4321);
            if (VALID === 1'b1) seen++;
            checks++;
            if ({VALID, BUSY, OVERRUN, BCD} !== {m_valid, m_active, m_ovr, m_bcd}) begin
                failures++;
                $display("FAIL reset_mid_after cyc=%0d got=%h exp=%h", cyc,
                         {VALID, BUSY, OVERRUN, BCD}, {m_valid, m_active, m_ovr, m_bcd});
            end
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_mid_valid count=%0d exp=0", seen);
        end
    endtask

    task automatic test_extremes();
        logic [15:0] vals [2];
        logic [19:0] exp_b [2];
        logic [19:0] got;
        vals[0] = 16'hFFFF; exp_b[0] = 20'h65535;
        vals[1] = 16'h0000; exp_b[1] = 20'h00000;
        for (int k = 0; k < 2; k++) begin
            got = 20'hFFFFF;
            step(1'b0, vals[k]);
            for (int i = 0; i < 20; i++) begin
                step(1'b1, vals[k]);
                if (VALID === 1'b1) got = BCD;
                checks++;
                if ({VALID, BUSY, OVERRUN, BCD} !== {m_valid, m_active, m_ovr, m_bcd}) begin
                    failures++;
                    $display("FAIL extremes_cycle cyc=%0d got=%h exp=%h", cyc,
                             {VALID, BUSY, OVERRUN, BCD}, {m_valid, m_active, m_ovr, m_bcd});
                end
            end
            checks++;
            if (got !== exp_b[k]) begin
                failures++;
                $display("FAIL extremes_value in=%h got=%h exp=%h", vals[k], got, exp_b[k]);
            end
        end
    endtask

    // Back-to-back products; with third set, a third rise overwrites the buffer.
    task automatic test_back_to_back(input bit third);
        logic [19:0] got [$];
        logic [19:0] exp_b1;
        bit          busy_gap;
        int          nvalid;
        exp_b1 = third ? 20'h00007 : 20'h00100;
        n_reset = 1'b0;
        #1;
        @(posedge clock);
        #1;
        n_reset = 1'b1;
        model_reset();
        step(1'b0, 16'd0);
        busy_gap = 0;
        nvalid   = 0;
        for (int i = 0; i < 45; i++) begin
            if (i == 0)                step(1'b1, 16'd999);
            else if (i == 5)           step(1'b1, 16'd100);
            else if (third && i == 8)  step(1'b1, 16'd7);
            else                       step(1'b0, 16'd0);
            if (VALID === 1'b1) begin
                got.push_back(BCD);
                nvalid++;
            end
            if (nvalid < 2 && BUSY !== 1'b1) busy_gap = 1;
            checks++;
            if ({VALID, BUSY, OVERRUN, BCD} !== {m_valid, m_active, m_ovr, m_bcd}) begin
                failures++;
                $display("FAIL b2b_cycle third=%0d cyc=%0d got=%h exp=%h", third, cyc,
                         {VALID, BUSY, OVERRUN, BCD}, {m_valid, m_active, m_ovr, m_bcd});
            end
        end
        checks++;
        if (got.size() != 2 || got[0] !== 20'h00999 || got[1] !== exp_b1 ||
            busy_gap || OVERRUN !== third) begin
            failures++;
            $display("FAIL b2b_result third=%0d n=%0d gap=%0d ovr=%b exp n=2 999,%h gap=0 ovr=%0d",
                     third, got.size(), busy_gap, OVERRUN, exp_b1, third);
        end
    endtask

    task automatic test_completion_edge();
        logic [19:0] got [$];
        bit          busy_gap;
        n_reset = 1'b0;
        #1;
        @(posedge clock);
        #1;
        n_reset = 1'b1;
        model_reset();
        step(1'b0, 16'd0);
        step(1'b1, 16'd50);
        busy_gap = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 16) step(1'b1, 16'd60);
            else         step(1'b0, 16'd0);
            if (VALID === 1'b1) got.push_back(BCD);
            if (got.size() < 2 && BUSY !== 1'b1) busy_gap = 1;
            checks++;
            if ({VALID, BUSY, OVERRUN, BCD} !== {m_valid, m_active, m_ovr, m_bcd}) begin
                failures++;
                $display("FAIL edge_cap_cycle cyc=%0d got=%h exp=%h", cyc,
                         {VALID, BUSY, OVERRUN, BCD}, {m_valid, m_active, m_ovr, m_bcd});
            end
        end
        checks++;
        if (got.size() != 2 || got[0] !== 20'h00050 || got[1] !== 20'h00060 ||
            busy_gap || OVERRUN !== 1'b0) begin
            failures++;
            $display("FAIL edge_cap_result n=%0d gap=%0d ovr=%b exp n=2 50,60 gap=0 ovr=0",
                     got.size(), busy_gap, OVERRUN);
        end
    endtask

    task automatic test_random();
        logic        r;
        logic [15:0] a;
        r = 1'b0;
        a = 16'd0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 3) r = ~r;
            if (!r) a = 16'($urandom());
            step(r, a);
            checks++;
            if ({VALID, BUSY, OVERRUN, BCD} !== {m_valid, m_active, m_ovr, m_bcd}) begin
                failures++;
                $display("FAIL random_cycle cyc=%0d got=%h exp=%h", cyc,
                         {VALID, BUSY, OVERRUN, BCD}, {m_valid, m_active, m_ovr, m_bcd});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid();
        test_extremes();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_completion_edge();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
